fp32_norm_seq: RTL

Sequential leading-one normalizer for the FP32 datapath. It accepts an unnormalized 32-bit magnitude with its exponent and walks a bit index from 31 downward. Each cycle it probes one bit through a 32:1 bit-select mux, driving the mux select and consuming the mux output. When it finds the leading one, it emits the left-justified magnitude, the leading-zero count and the adjusted exponent over a valid/ready handshake.

---
 rtl/fp32_pkg.sv | 14 +
 rtl/mux32.sv | 10 +
 rtl/fp32_norm_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared types and constants for the FP32 normalizer datapath
package fp32_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam int MAG_W   = 32;
    localparam int LZ_W    = 6;
    localparam int LZ_ZERO = 32;

endpackage

// File: rtl/mux32.sv
// mux32: 32:1 single-bit select
module mux32 (
    input  logic [31:0] i,
    input  logic [4:0]  s,
    output logic        o
);

    assign o = i[s];

endmodule

// File: rtl/fp32_norm_seq.sv
// fp32_norm_seq: bit-serial leading-one normalizer with exponent adjust and underflow clamp
module fp32_norm_seq
    import fp32_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_mag,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_mag,
    output logic [EXP_W-1:0] out_exp,
    output logic [5:0]       out_lz,
    output logic             out_zero,
    output logic             out_uflow
);

    state_t             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [4:0]         idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [MAG_W-1:0]   out_mag_q, out_mag_d;
    logic [EXP_W-1:0]   out_exp_q, out_exp_d;
    logic [LZ_W-1:0]    out_lz_q, out_lz_d;
    logic               out_zero_q, out_zero_d;
    logic               out_uflow_q, out_uflow_d;
    logic               probe;
    logic [LZ_W-1:0]    lz;
    logic [EXP_W:0]     lz_ext;

    mux32 u_mux (
        .i (mag_q),
        .s (idx_q),
        .o (probe)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_mag   = out_mag_q;
    assign out_exp   = out_exp_q;
    assign out_lz    = out_lz_q;
    assign out_zero  = out_zero_q;
    assign out_uflow = out_uflow_q;

    // next-state: capture in IDLE, probe one bit per cycle in SCAN, hold result in DONE
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_mag_d   = out_mag_q;
        out_exp_d   = out_exp_q;
        out_lz_d    = out_lz_q;
        out_zero_d  = out_zero_q;
        out_uflow_d = out_uflow_q;
        lz          = {1'b0, 5'd31 - idx_q};
        lz_ext      = (EXP_W+1)'(lz);
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mag_d = in_mag;
                    exp_d = in_exp;
                    idx_d = 5'd31;
                    if (in_mag == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_zero_d  = 1'b1;
                        out_lz_d    = LZ_W'(LZ_ZERO);
                        out_mag_d   = '0;
                        out_exp_d   = '0;
                        out_uflow_d = 1'b0;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (probe) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_zero_d  = 1'b0;
                    out_lz_d    = lz;
                    // a shift past the exponent would go below zero, so clamp to a denormal
                    out_uflow_d = lz_ext >= {1'b0, exp_q};
                    out_exp_d   = out_uflow_d ? '0 : exp_q - EXP_W'(lz);
                    out_mag_d   = out_uflow_d ? mag_q << exp_q[4:0] : mag_q << lz;
                end else begin
                    idx_d = idx_q - 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            exp_q       <= '0;
            idx_q       <= 5'd31;
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
            out_exp_q   <= '0;
            out_lz_q    <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_mag_q   <= out_mag_d;
            out_exp_q   <= out_exp_d;
            out_lz_q    <= out_lz_d;
            out_zero_q  <= out_zero_d;
            out_uflow_q <= out_uflow_d;
        end
    end

endmodule
